// File: rtl/grf_scoreboard_if.sv
// Register-file / scoreboard bus: read ports, write port, issue port and pending count.
// Pure wiring; no backpressure, every port is accepted in the cycle it is driven.
interface grf_scoreboard_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] rs_addr;
  logic [ADDR_W-1:0] rt_addr;
  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;
  logic              rs_pend;
  logic              rt_pend;
  logic              we;
  logic [ADDR_W-1:0] wa;
  logic [DATA_W-1:0] wd;
  logic              iss_en;
  logic [ADDR_W-1:0] iss_addr;
  logic [ADDR_W:0]   pend_cnt;

  modport master (
    output rs_addr, rt_addr, we, wa, wd, iss_en, iss_addr,
    input  rs_data, rt_data, rs_pend, rt_pend, pend_cnt
  );

  modport slave (
    input  rs_addr, rt_addr, we, wa, wd, iss_en, iss_addr,
    output rs_data, rt_data, rs_pend, rt_pend, pend_cnt
  );
endinterface

// File: rtl/grf_scoreboard.sv
// Two-read/one-write register file with per-register pending bits; reads are combinational,
// writes and issues land on the next rising edge; no backpressure.
module grf_scoreboard #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic            clk,
  input  logic            clr,
  grf_scoreboard_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam bit ZR    = (ZERO_REG != 0);
  localparam bit BP    = (BYPASS != 0);

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  pend;
  logic [DEPTH-1:0]  pend_next;
  logic [ADDR_W:0]   cnt;
  logic              wa_zero;
  logic              iss_zero;
  logic [DATA_W-1:0] rs_q;
  logic [DATA_W-1:0] rt_q;
  logic              rs_p;
  logic              rt_p;

  assign wa_zero  = ZR && (bus.wa == '0);
  assign iss_zero = ZR && (bus.iss_addr == '0);

  // Issue is applied after the write clear so a same-edge new producer keeps the bit set.
  always_comb begin
    pend_next = pend;
    if (bus.we) pend_next[bus.wa] = 1'b0;
    if (bus.iss_en && !iss_zero) pend_next[bus.iss_addr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      pend <= '0;
    end else begin
      if (bus.we && !wa_zero) regs[bus.wa] <= bus.wd;
      pend <= pend_next;
    end
  end

  always_comb begin
    rs_q = regs[bus.rs_addr];
    rs_p = pend[bus.rs_addr];
    if (BP && bus.we && (bus.wa == bus.rs_addr)) begin
      rs_q = bus.wd;
      rs_p = 1'b0;
    end
    if (ZR && (bus.rs_addr == '0)) begin
      rs_q = '0;
      rs_p = 1'b0;
    end
  end

  always_comb begin
    rt_q = regs[bus.rt_addr];
    rt_p = pend[bus.rt_addr];
    if (BP && bus.we && (bus.wa == bus.rt_addr)) begin
      rt_q = bus.wd;
      rt_p = 1'b0;
    end
    if (ZR && (bus.rt_addr == '0)) begin
      rt_q = '0;
      rt_p = 1'b0;
    end
  end

  always_comb begin
    cnt = '0;
    for (int i = 0; i < DEPTH; i++) cnt = cnt + (ADDR_W+1)'(pend[i]);
  end

  assign bus.rs_data  = rs_q;
  assign bus.rt_data  = rt_q;
  assign bus.rs_pend  = rs_p;
  assign bus.rt_pend  = rt_p;
  assign bus.pend_cnt = cnt;
endmodule

// File: doc/grf_scoreboard.md
GRF_SCOREBOARD -- requirements
Module: grf_scoreboard

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning register width in bits.
REQ-002 SHALL have parameter ADDR_W, default 5, meaning address width; DEPTH = 2**ADDR_W registers.
REQ-003 SHALL have parameter ZERO_REG, default 1, meaning 1 hardwires register 0 to zero and never pending.
REQ-004 SHALL have parameter BYPASS, default 1, meaning 1 forwards same-cycle write data and clears to the read ports.
REQ-005 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 SHALL have port clr  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port rs_addr  input  ADDR_W  read port A address.
REQ-008 SHALL have port rt_addr  input  ADDR_W  read port B address.
REQ-009 SHALL have port rs_data  output  DATA_W  read port A data, combinational.
REQ-010 SHALL have port rt_data  output  DATA_W  read port B data, combinational.
REQ-011 SHALL have port rs_pend  output  1  register at rs_addr awaits an outstanding write.
REQ-012 SHALL have port rt_pend  output  1  register at rt_addr awaits an outstanding write.
REQ-013 SHALL have port we  input  1  write enable.
REQ-014 SHALL have port wa  input  ADDR_W  write address.
REQ-015 SHALL have port wd  input  DATA_W  write data.
REQ-016 SHALL have port iss_en  input  1  issue: mark iss_addr pending.
REQ-017 SHALL have port iss_addr  input  ADDR_W  destination of issuing instruction.
REQ-018 SHALL have port pend_cnt  output  ADDR_W+1  number of pending registers.

Function
REQ-019 SHALL store DEPTH registers of DATA_W bits plus a DEPTH-bit pending vector.
REQ-020 SHALL update reg[wa] <= wd on rising edge when we=1 and clr=0, except wa=0 with ZERO_REG=1 (ignored).
REQ-021 SHALL read asynchronously: rs_data = reg[rs_addr], rt_data = reg[rt_addr]; address 0 returns 0 when ZERO_REG=1.
REQ-022 SHALL, when BYPASS=1 and we=1 and wa equals a read address (and is not a hardwired zero), drive wd on that read port in the same cycle.
REQ-023 SHALL set pend[iss_addr] on rising edge when iss_en=1, except iss_addr=0 with ZERO_REG=1.
REQ-024 SHALL clear pend[wa] on rising edge when we=1.
REQ-025 SHALL, on simultaneous iss_en and we to the same address, leave pend set (new producer wins); register data still takes wd.
REQ-026 SHALL drive rs_pend = pend[rs_addr], masked to 0 in the same cycle when BYPASS=1 and we=1 and wa=rs_addr; rt_pend likewise.
REQ-027 SHALL keep pend_cnt equal to the population count of the registered pend vector, updated one cycle after the causing edge; max value DEPTH (or DEPTH-1 with ZERO_REG=1).
REQ-028 SHALL treat writes to non-pending registers as legal (plain write, pend unchanged at 0).
REQ-029 SHALL treat iss_en to an already pending register as legal (stays set, pend_cnt unchanged).
REQ-030 SHALL have zero-cycle read latency and one-cycle write-to-storage latency.

Reset
REQ-031 SHALL, on rising edge with clr=1, clear all registers and all pend bits, overriding we and iss_en in that cycle.
REQ-032 SHALL, after reset, present rs_data=rt_data=0, rs_pend=rt_pend=0, pend_cnt=0.
REQ-033 SHALL, with clr asserted mid-stream, discard all outstanding pending state with no residual effect after deassertion.

Verification
REQ-034 SHALL pass: clr 1 cycle, then read rs_addr=7, rt_addr=31 -> rs_data=0, rt_data=0, pend_cnt=0.
REQ-035 SHALL pass: we=1, wa=5, wd=0x12345678, rs_addr=5 same cycle -> rs_data=0x12345678 that cycle (BYPASS=1); BYPASS=0 -> old value, new value next cycle.
REQ-036 SHALL pass: we=1, wa=0, wd=0xFFFFFFFF, then read rs_addr=0 -> rs_data=0 (ZERO_REG=1); iss_en to 0 -> pend_cnt stays 0.
REQ-037 SHALL pass: iss_en addr 3, next cycle rs_addr=3 -> rs_pend=1, pend_cnt=1; then we wa=3 -> rs_pend=0 that cycle, pend_cnt=0 next cycle.
REQ-038 SHALL pass: iss_en addr 9 and we wa=9 wd=0xA5 same edge -> reg[9]=0xA5, pend[9]=1, pend_cnt=1.
REQ-039 SHALL pass: issue addresses 1..4 and write reg 2=0x55, then clr with we=1 wa=6 -> all regs 0, pend_cnt=0, reg[6]=0.
